// File: rtl/axi_riscv_lrsc_table.sv
// LR/SC reservation table: tracks per-ID granule reservations, resolves
// store-conditionals and drops reservations hit by snooped writes.
module axi_riscv_lrsc_table #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned NUM_RES    = 4,
   parameter int unsigned GRAN_BYTES = 8,
   parameter int unsigned TIMEOUT    = 0
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           lr_valid_i,
   output logic                           lr_ready_o,
   input  logic [ID_WIDTH-1:0]            lr_id_i,
   input  logic [ADDR_WIDTH-1:0]          lr_addr_i,
   input  logic                           sc_valid_i,
   output logic                           sc_ready_o,
   input  logic [ID_WIDTH-1:0]            sc_id_i,
   input  logic [ADDR_WIDTH-1:0]          sc_addr_i,
   output logic                           sc_rsp_valid_o,
   input  logic                           sc_rsp_ready_i,
   output logic                           sc_rsp_ok_o,
   output logic [ID_WIDTH-1:0]            sc_rsp_id_o,
   input  logic                           wr_valid_i,
   input  logic [ADDR_WIDTH-1:0]          wr_addr_i,
   output logic [$clog2(NUM_RES+1)-1:0]   res_count_o
);

   localparam int unsigned GRAN_LSB = $clog2(GRAN_BYTES);
   localparam int unsigned GA_W     = ADDR_WIDTH - GRAN_LSB;
   localparam int unsigned CNT_W    = $clog2(NUM_RES + 1);
   localparam int unsigned PTR_W    = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;

   logic [GA_W-1:0]     lr_gaddr, sc_gaddr, wr_gaddr;
   logic                unused_low_bits;
   logic                lr_fire, sc_fire, sc_ok, evict;
   logic [NUM_RES-1:0]  valid_reg, valid_next;
   logic [NUM_RES-1:0]  expired, v_snp, sc_hit, sc_clr, v_sc, lr_hit, alloc_sel;
   logic [PTR_W-1:0]    victim_ptr_reg;
   logic [CNT_W-1:0]    count_reg, count_next;
   logic                rsp_valid_reg, rsp_ok_reg;
   logic [ID_WIDTH-1:0] rsp_id_reg;

   assign lr_gaddr = lr_addr_i[ADDR_WIDTH-1:GRAN_LSB];
   assign sc_gaddr = sc_addr_i[ADDR_WIDTH-1:GRAN_LSB];
   assign wr_gaddr = wr_addr_i[ADDR_WIDTH-1:GRAN_LSB];
   assign unused_low_bits = ^{lr_addr_i[GRAN_LSB-1:0], sc_addr_i[GRAN_LSB-1:0],
                              wr_addr_i[GRAN_LSB-1:0]};

   assign lr_ready_o     = !rst_i;
   assign sc_ready_o     = !rst_i && (!rsp_valid_reg || sc_rsp_ready_i);
   assign lr_fire        = lr_valid_i && lr_ready_o;
   assign sc_fire        = sc_valid_i && sc_ready_o;
   assign sc_ok          = |sc_hit;
   assign sc_rsp_valid_o = rsp_valid_reg;
   assign sc_rsp_ok_o    = rsp_ok_reg;
   assign sc_rsp_id_o    = rsp_id_reg;
   assign res_count_o    = count_reg;

   // Per-entry pipeline of effects: expiry -> snoop -> SC clear -> LR install.
   generate
      for (genvar gi = 0; gi < NUM_RES; gi++) begin : g_ent
         logic [ID_WIDTH-1:0] id_reg;
         logic [GA_W-1:0]     gaddr_reg;

         if (TIMEOUT > 0) begin : g_age
            localparam int unsigned AGE_W = $clog2(TIMEOUT + 1);
            logic [AGE_W-1:0] age_reg;

            assign expired[gi] = valid_reg[gi] && (age_reg == AGE_W'(TIMEOUT - 1));

            always_ff @(posedge clk_i) begin
               if (rst_i)
                  age_reg <= '0;
               else if (alloc_sel[gi])
                  age_reg <= '0;
               else if (valid_reg[gi])
                  age_reg <= age_reg + AGE_W'(1);
            end
         end else begin : g_no_age
            assign expired[gi] = 1'b0;
         end

         assign v_snp[gi]  = valid_reg[gi] && !expired[gi] &&
                             !(wr_valid_i && (gaddr_reg == wr_gaddr));
         assign sc_hit[gi] = v_snp[gi] && (id_reg == sc_id_i) && (gaddr_reg == sc_gaddr);
         assign sc_clr[gi] = sc_fire && ((id_reg == sc_id_i) ||
                                         (sc_ok && (gaddr_reg == sc_gaddr)));
         assign v_sc[gi]   = v_snp[gi] && !sc_clr[gi];
         assign lr_hit[gi] = v_sc[gi] && (id_reg == lr_id_i);
         assign valid_next[gi] = v_sc[gi] || alloc_sel[gi];

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               id_reg    <= '0;
               gaddr_reg <= '0;
            end else if (alloc_sel[gi]) begin
               id_reg    <= lr_id_i;
               gaddr_reg <= lr_gaddr;
            end
         end
      end
   endgenerate

   // LR slot choice: same-ID entry, else lowest free, else round-robin victim.
   always_comb begin
      alloc_sel = '0;
      evict     = 1'b0;
      if (lr_fire) begin
         if (|lr_hit) begin
            alloc_sel = lr_hit;
         end else if (!(&v_sc)) begin
            for (int i = NUM_RES - 1; i >= 0; i--) begin
               if (!v_sc[i]) alloc_sel = NUM_RES'(1) << i;
            end
         end else begin
            alloc_sel[victim_ptr_reg] = 1'b1;
            evict = 1'b1;
         end
      end
   end

   always_comb begin
      count_next = '0;
      for (int i = 0; i < NUM_RES; i++) begin
         count_next = count_next + CNT_W'(valid_next[i]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_reg      <= '0;
         victim_ptr_reg <= '0;
         count_reg      <= '0;
         rsp_valid_reg  <= 1'b0;
         rsp_ok_reg     <= 1'b0;
         rsp_id_reg     <= '0;
      end else begin
         valid_reg <= valid_next;
         count_reg <= count_next;
         if (evict) begin
            victim_ptr_reg <= (victim_ptr_reg == PTR_W'(NUM_RES - 1)) ? '0
                              : victim_ptr_reg + PTR_W'(1);
         end
         if (sc_fire) begin
            rsp_valid_reg <= 1'b1;
            rsp_ok_reg    <= sc_ok;
            rsp_id_reg    <= sc_id_i;
         end else if (sc_rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_riscv_lrsc_table.sv
// Bench for the LR/SC table: vector table plus hand-written back-pressure,
// timeout and reset sequences; SC responses are checked from a scoreboard.
module tb_axi_riscv_lrsc_table;

   typedef struct {
      logic        lr_v;
      logic [3:0]  lr_id;
      logic [63:0] lr_addr;
      logic        sc_v;
      logic [3:0]  sc_id;
      logic [63:0] sc_addr;
      logic        wr_v;
      logic [63:0] wr_addr;
      logic        exp_ok;
      int          exp_cnt;
   } vec_t;

   typedef struct {
      logic       ok;
      logic [3:0] id;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        lr_valid = 1'b0, sc_valid = 1'b0, wr_valid = 1'b0, sc_rsp_ready = 1'b1;
   logic [3:0]  lr_id = '0, sc_id = '0;
   logic [63:0] lr_addr = '0, sc_addr = '0, wr_addr = '0;

   logic        lr_ready, sc_ready, rsp_valid, rsp_ok;
   logic [3:0]  rsp_id;
   logic [2:0]  res_count;
   logic        to_lr_ready, to_sc_ready, to_rsp_valid, to_rsp_ok;
   logic [3:0]  to_rsp_id;
   logic [2:0]  to_res_count;

   int   n_cmp = 0;
   int   n_err = 0;
   rsp_t sb_q[$];
   rsp_t mon_e;
   vec_t tbl[$];

   always #5 clk = ~clk;

   axi_riscv_lrsc_table #(.ADDR_WIDTH(64), .ID_WIDTH(4), .NUM_RES(4),
                          .GRAN_BYTES(8), .TIMEOUT(0)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .lr_valid_i(lr_valid), .lr_ready_o(lr_ready), .lr_id_i(lr_id), .lr_addr_i(lr_addr),
      .sc_valid_i(sc_valid), .sc_ready_o(sc_ready), .sc_id_i(sc_id), .sc_addr_i(sc_addr),
      .sc_rsp_valid_o(rsp_valid), .sc_rsp_ready_i(sc_rsp_ready),
      .sc_rsp_ok_o(rsp_ok), .sc_rsp_id_o(rsp_id),
      .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .res_count_o(res_count)
   );

   // Second instance with expiry enabled, fed the same stimulus.
   axi_riscv_lrsc_table #(.ADDR_WIDTH(64), .ID_WIDTH(4), .NUM_RES(4),
                          .GRAN_BYTES(8), .TIMEOUT(4)) dut_to (
      .clk_i(clk), .rst_i(rst_i),
      .lr_valid_i(lr_valid), .lr_ready_o(to_lr_ready), .lr_id_i(lr_id), .lr_addr_i(lr_addr),
      .sc_valid_i(sc_valid), .sc_ready_o(to_sc_ready), .sc_id_i(sc_id), .sc_addr_i(sc_addr),
      .sc_rsp_valid_o(to_rsp_valid), .sc_rsp_ready_i(sc_rsp_ready),
      .sc_rsp_ok_o(to_rsp_ok), .sc_rsp_id_o(to_rsp_id),
      .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .res_count_o(to_res_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic lv, input logic [3:0] li, input logic [63:0] la,
                               input logic sv, input logic [3:0] si, input logic [63:0] sa,
                               input logic wv, input logic [63:0] wa,
                               input logic ok, input int cnt);
      vec_t v;
      v.lr_v = lv; v.lr_id = li; v.lr_addr = la;
      v.sc_v = sv; v.sc_id = si; v.sc_addr = sa;
      v.wr_v = wv; v.wr_addr = wa;
      v.exp_ok = ok; v.exp_cnt = cnt;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      lr_valid = v.lr_v; lr_id = v.lr_id; lr_addr = v.lr_addr;
      sc_valid = v.sc_v; sc_id = v.sc_id; sc_addr = v.sc_addr;
      wr_valid = v.wr_v; wr_addr = v.wr_addr;
      if (v.sc_v) sb_q.push_back('{ok: v.exp_ok, id: v.sc_id});
      @(posedge clk); #1;
      if (v.sc_v) chk("sc_latency", rsp_valid, 1);
      if (v.exp_cnt >= 0) chk("res_count", res_count, v.exp_cnt);
      lr_valid = 1'b0; sc_valid = 1'b0; wr_valid = 1'b0;
   endtask

   // Scoreboard: one response is consumed per cycle it is valid with ready high.
   always @(negedge clk) begin
      if (!rst_i && rsp_valid && sc_rsp_ready) begin
         $display("rsp id=%0d ok=%0d", rsp_id, rsp_ok);
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_rsp: got id %0d, expected no response", rsp_id);
         end else begin
            mon_e = sb_q.pop_front();
            chk("rsp_ok", rsp_ok, mon_e.ok);
            chk("rsp_id", rsp_id, mon_e.id);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Basic success
      tbl.push_back(mk(1, 2, 'h1000, 0, 0, 0,      0, 0,      0, 1));
      tbl.push_back(mk(0, 0, 0,      1, 2, 'h1004, 0, 0,      1, 0));
      tbl.push_back(mk(0, 0, 0,      0, 0, 0,      0, 0,      0, 0));
      // Snoop kill, then snoop on the neighbouring granule
      tbl.push_back(mk(1, 1, 'h2000, 0, 0, 0,      0, 0,      0, 1));
      tbl.push_back(mk(0, 0, 0,      0, 0, 0,      1, 'h2007, 0, 0));
      tbl.push_back(mk(0, 0, 0,      1, 1, 'h2000, 0, 0,      0, 0));
      tbl.push_back(mk(1, 1, 'h2000, 0, 0, 0,      0, 0,      0, 1));
      tbl.push_back(mk(0, 0, 0,      0, 0, 0,      1, 'h2008, 0, 1));
      tbl.push_back(mk(0, 0, 0,      1, 1, 'h2000, 0, 0,      1, 0));
      // Eviction: five IDs into four slots, id 0 evicted
      tbl.push_back(mk(1, 0, 'h4000, 0, 0, 0,      0, 0,      0, 1));
      tbl.push_back(mk(1, 1, 'h4010, 0, 0, 0,      0, 0,      0, 2));
      tbl.push_back(mk(1, 2, 'h4020, 0, 0, 0,      0, 0,      0, 3));
      tbl.push_back(mk(1, 3, 'h4030, 0, 0, 0,      0, 0,      0, 4));
      tbl.push_back(mk(1, 4, 'h4040, 0, 0, 0,      0, 0,      0, 4));
      tbl.push_back(mk(0, 0, 0,      1, 0, 'h4000, 0, 0,      0, 4));
      tbl.push_back(mk(0, 0, 0,      1, 4, 'h4040, 0, 0,      1, 3));
      tbl.push_back(mk(0, 0, 0,      1, 1, 'h4010, 0, 0,      1, 2));
      // Cross-ID clear on a shared granule
      tbl.push_back(mk(1, 3, 'h3000, 0, 0, 0,      0, 0,      0, 2));
      tbl.push_back(mk(1, 5, 'h3000, 0, 0, 0,      0, 0,      0, 3));
      tbl.push_back(mk(0, 0, 0,      1, 3, 'h3000, 0, 0,      1, 1));
      tbl.push_back(mk(0, 0, 0,      1, 5, 'h3000, 0, 0,      0, 1));
      // Same-cycle LR and SC on one ID: SC sees old reservation
      tbl.push_back(mk(1, 2, 'h5000, 1, 2, 'h4020, 0, 0,      1, 1));
      tbl.push_back(mk(0, 0, 0,      1, 2, 'h5000, 0, 0,      1, 0));
      // LR wins over a same-cycle snoop; SC to another granule fails
      tbl.push_back(mk(1, 6, 'h6000, 0, 0, 0,      1, 'h6000, 0, 1));
      tbl.push_back(mk(0, 0, 0,      1, 6, 'h6008, 0, 0,      0, 0));
      tbl.push_back(mk(0, 0, 0,      0, 0, 0,      0, 0,      0, 0));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_ok", rsp_ok, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_res_count", res_count, 0);
      chk("rst_lr_ready", lr_ready, 0);
      chk("rst_sc_ready", sc_ready, 0);
      rst_i = 1'b0;
      #1;
      chk("lr_ready_run", lr_ready, 1);
      chk("sc_ready_run", sc_ready, 1);

      foreach (tbl[i]) apply(tbl[i]);

      // Back-pressure: second SC waits, first response holds
      apply(mk(1, 7, 'hA000, 0, 0, 0, 0, 0, 0, -1));
      apply(mk(1, 8, 'hB000, 0, 0, 0, 0, 0, 0, -1));
      sc_rsp_ready = 1'b0;
      apply(mk(0, 0, 0, 1, 7, 'hA000, 0, 0, 1, -1));
      sc_valid = 1'b1; sc_id = 4'd8; sc_addr = 'hB000;
      sb_q.push_back('{ok: 1'b1, id: 4'd8});
      #1;
      chk("bp_sc_ready", sc_ready, 0);
      repeat (2) begin
         @(posedge clk); #1;
         chk("bp_sc_ready_hold", sc_ready, 0);
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_id", rsp_id, 7);
         chk("bp_rsp_ok", rsp_ok, 1);
      end
      sc_rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", sc_ready, 1);
      @(posedge clk); #1;
      sc_valid = 1'b0;
      chk("bp_second_valid", rsp_valid, 1);
      @(posedge clk); #1;
      chk("bp_drained", rsp_valid, 0);

      // Timeout window on the TIMEOUT=4 instance
      apply(mk(1, 9, 'hC000, 0, 0, 0, 0, 0, 0, -1));
      repeat (2) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
      apply(mk(0, 0, 0, 1, 9, 'hC000, 0, 0, 1, -1));
      chk("to_t3_valid", to_rsp_valid, 1);
      chk("to_t3_ok", to_rsp_ok, 1);
      chk("to_t3_id", to_rsp_id, 9);
      apply(mk(1, 10, 'hD000, 0, 0, 0, 0, 0, 0, -1));
      repeat (3) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
      apply(mk(0, 0, 0, 1, 10, 'hD000, 0, 0, 1, -1));
      chk("to_t4_valid", to_rsp_valid, 1);
      chk("to_t4_ok", to_rsp_ok, 0);
      chk("to_t4_id", to_rsp_id, 10);
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, -1));

      // Reset with a response pending: response and reservations are lost
      sc_rsp_ready = 1'b0;
      apply(mk(1, 11, 'hE000, 0, 0, 0, 0, 0, 0, 1));
      lr_valid = 1'b0;
      sc_valid = 1'b1; sc_id = 4'd11; sc_addr = 'hE000;
      @(posedge clk); #1;
      sc_valid = 1'b0;
      chk("pre_rst_pending", rsp_valid, 1);
      rst_i = 1'b1;
      #1;
      chk("mid_rst_lr_ready", lr_ready, 0);
      chk("mid_rst_sc_ready", sc_ready, 0);
      @(posedge clk); #1;
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_rsp_ok", rsp_ok, 0);
      chk("mid_rst_rsp_id", rsp_id, 0);
      chk("mid_rst_count", res_count, 0);
      rst_i = 1'b0;
      sc_rsp_ready = 1'b1;
      apply(mk(0, 0, 0, 1, 11, 'hE000, 0, 0, 0, 0));
      repeat (3) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
      chk("sb_empty", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
